// File: rtl/mac_seq_ctrl.sv
// Sequenced multiply-accumulate controller.
// One dot product of K signed operand pairs per start. It is seeded with a
// bias and delivered through a valid/ready handshake on S.
module mac_seq_ctrl #(
  parameter int N = 8,
  parameter int K = 3,
  localparam int W = 2*N + K - 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] bias,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         clear,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] S,
  output logic         busy
);

  localparam int CW = (K > 1) ? $clog2(K) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]          state, state_nx;
  logic [CW-1:0]       cnt;
  logic [W-1:0]        acc;
  logic signed [2*N-1:0] prod;
  logic [W-1:0]        prod_ext;
  logic                beat, last, take_start;

  // Full-width signed product. It is sign-extended into the accumulator
  // width, and the sum then wraps modulo 2^W.
  assign prod     = $signed(A) * $signed(B);
  assign prod_ext = {{(W-2*N){prod[2*N-1]}}, prod};

  assign beat       = in_valid && (state == ACC);
  assign last       = (cnt == CW'(K-1));
  assign take_start = start && (state == IDLE);

  // Next state. clear overrides every other transition.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)        state_nx = ACC;
      ACC:     if (beat && last) state_nx = DONE;
      DONE:    if (out_ready)    state_nx = IDLE;
      default:                   state_nx = IDLE;
    endcase
    if (clear) state_nx = IDLE;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Beat counter. It counts 0..K-1 and is rearmed on completion, so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 cnt <= '0;
    else if (clear)          cnt <= '0;
    else if (take_start)     cnt <= '0;
    else if (beat && last)   cnt <= '0;
    else if (beat)           cnt <= cnt + CW'(1);
  end

  // Accumulator. It is seeded with bias and bumped only on accepted beats.
  // S reads it directly, so the result is a registered value that holds through DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      acc <= '0;
    else if (clear)               acc <= acc;
    else if (take_start)          acc <= bias;
    else if (beat)                acc <= acc + prod_ext;
  end

  // All handshake outputs decode from registered state only. This keeps
  // A, B, in_valid and out_ready off any combinational path to an output.
  assign in_ready  = (state == ACC);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign S         = acc;

endmodule
